// File: rtl/fetch_sequencer.sv
// Fetch sequencer: one outstanding instruction-memory request, a single-entry
// decode buffer, PC-enable pulses and delay-slot-aware PC-source selection.
module fetch_sequencer #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int PCSRC_W        = 3
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        instr_out,
  output logic               instr_valid,
  input  logic               d_stall,
  input  logic               redir_valid,
  input  logic [PCSRC_W-1:0] redir_src,
  output logic               pc_en,
  output logic [PCSRC_W-1:0] pc_src,
  output logic               fetch_err,
  output logic               redir_err
);

  // state   | meaning
  // S_IDLE  | no request out; waits for the buffer to be empty or draining
  // S_WAIT  | request held on imem_req until imem_ack or timeout
  // S_ERROR | memory timed out; only reset leaves this state
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ERROR = 2'd2
  } state_e;

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [31:0]          instr_q, instr_d;
  logic                 valid_q, valid_d;
  logic                 pend_q, pend_d;
  logic [PCSRC_W-1:0]   pend_src_q, pend_src_d;
  logic                 ferr_q, ferr_d;
  logic                 rerr_q, rerr_d;
  logic                 consume;
  logic                 redir_legal;
  logic                 pc_en_c;
  logic [PCSRC_W-1:0]   pc_src_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      pend_q     <= 1'b0;
      pend_src_q <= '0;
      ferr_q     <= 1'b0;
      rerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      pend_q     <= pend_d;
      pend_src_q <= pend_src_d;
      ferr_q     <= ferr_d;
      rerr_q     <= rerr_d;
    end
  end

  always_comb begin
    consume     = valid_q & ~d_stall;
    // Only branch, jump and register redirects count; other codes are dropped.
    redir_legal = redir_valid && (redir_src != '0) && (32'(redir_src) < 32'd4);

    state_d    = state_q;
    timer_d    = timer_q;
    instr_d    = instr_q;
    valid_d    = valid_q & ~consume;
    pend_d     = pend_q;
    pend_src_d = pend_src_q;
    ferr_d     = ferr_q;
    rerr_d     = rerr_q;
    pc_en_c    = 1'b0;
    pc_src_c   = '0;

    case (state_q)
      S_IDLE: begin
        if (!valid_q || consume) begin
          state_d = S_WAIT;
          timer_d = '0;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          pc_en_c = 1'b1;
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = S_IDLE;
          timer_d = '0;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_ERROR;
          ferr_d  = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase

    // A redirect lands on the pc_en that completes the delay-slot fetch.
    if (pc_en_c) begin
      if (pend_q)           pc_src_c = pend_src_q;
      else if (redir_legal) pc_src_c = redir_src;
      pend_d = 1'b0;
      if (pend_q && redir_legal) rerr_d = 1'b1;
    end else if (redir_legal) begin
      if (pend_q) begin
        rerr_d = 1'b1;
      end else begin
        pend_d     = 1'b1;
        pend_src_d = redir_src;
      end
    end
  end

  assign imem_req    = (state_q == S_WAIT);
  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign pc_en       = pc_en_c;
  assign pc_src      = pc_src_c;
  assign fetch_err   = ferr_q;
  assign redir_err   = rerr_q;

endmodule
